// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, blank pattern and active-low hex-to-segment table.
package seg7_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {BLANK, SHOW} scan_state_t;
  localparam seg_t SEG_BLANK = 7'b1111111;
  // Active-low segments, bit6 = a .. bit0 = g, indexed by nibble value.
  localparam seg_t HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic seg_t hex2seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: slot timer, BLANK/SHOW sequencing, round-robin digit index and wrap pulse.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IW           = $clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  output scan_state_t   state_o,
  output logic [IW-1:0] idx_o,
  output logic          wrap_o
);
  localparam int CMAX = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX > 2 ? CMAX : 2);
  localparam scan_state_t RST_STATE = BLANK_CYCLES == 0 ? SHOW : BLANK;
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wrap_q, wrap_d, last;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    wrap_d = 1'b0;
    last = idx_q == IW'(NUM_DIGITS - 1);
    if (state_q == BLANK) begin
      if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
        state_d = SHOW;
        cnt_d = '0;
      end
    end else if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
      state_d = RST_STATE;
      cnt_d = '0;
      idx_d = last ? '0 : idx_q + 1'b1;
      wrap_d = last;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q <= '0;
      idx_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wrap_q <= wrap_d;
    end
  end
  assign state_o = state_q;
  assign idx_o = idx_q;
  assign wrap_o = wrap_q;
endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: shadowed, time-multiplexed common-anode 7-segment driver with registered pins.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    scan_wrap
);
  localparam int IW = $clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2);
  scan_state_t state;
  logic [IW-1:0] idx, hi;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0] dpm_q, en_q, anode_q, anode_d;
  logic lz_q, dp_q, dp_d, vis, show;
  logic [3:0] nib;
  seg_t cathode_q, cathode_d;
  seg7_scan_ctrl #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IW(IW)
  ) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .state_o(state),
    .idx_o(idx),
    .wrap_o(scan_wrap)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      dpm_q <= '0;
      en_q <= '0;
      lz_q <= 1'b0;
    end else if (load) begin
      val_q <= value;
      dpm_q <= dp_in;
      en_q <= digit_en;
      lz_q <= lz_suppress;
    end
  end
  // Digit 0 is never above hi, so an all-zero value still lights a single "0".
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_DIGITS; i++) hi = (val_q[4*i +: 4] != 4'h0) ? IW'(i) : hi;
    nib = val_q[4*idx +: 4];
    show = state == SHOW;
    vis = en_q[idx] && !(lz_q && idx > hi);
    anode_d = (show && vis) ? ~(NUM_DIGITS'(1) << idx) : '1;
    cathode_d = show ? hex2seg(nib) : SEG_BLANK;
    dp_d = !(show && vis && dpm_q[idx]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_q <= '1;
      cathode_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      anode_q <= anode_d;
      cathode_q <= cathode_d;
      dp_q <= dp_d;
    end
  end
  assign anode = anode_q;
  assign cathode = cathode_q;
  assign dp = dp_q;
endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: scoreboard bench; stimulus queues hand-computed per-cycle pin vectors, monitor compares.
module tb_seg7_mux_driver;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, en = '0;
  logic [3:0] anode;
  logic [6:0] cathode, cat1;
  logic dp, sw, an1, dp1, sw1;
  int checks = 0, failures = 0;
  logic [12:0] q0[$];
  logic [9:0] q1[$];
  always #5 clk = ~clk;
  seg7_mux_driver #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(en),
    .lz_suppress(lz), .load(load), .anode(anode), .cathode(cathode), .dp(dp), .scan_wrap(sw)
  );
  seg7_mux_driver #(.NUM_DIGITS(1), .DIGIT_CYCLES(4), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .value(4'h8), .dp_in(1'b1), .digit_en(1'b1),
    .lz_suppress(1'b0), .load(load), .anode(an1), .cathode(cat1), .dp(dp1), .scan_wrap(sw1)
  );
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      logic [12:0] e;
      e = q0.pop_front();
      checks++;
      if ({anode, cathode, dp, sw} !== e) begin
        failures++;
        $display("FAIL u0 t=%0t got an=%b cat=%b dp=%b wrap=%b exp an=%b cat=%b dp=%b wrap=%b",
                 $time, anode, cathode, dp, sw, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    if (q1.size() > 0) begin
      logic [9:0] e;
      e = q1.pop_front();
      checks++;
      if ({an1, cat1, dp1, sw1} !== e) begin
        failures++;
        $display("FAIL u1 t=%0t got an=%b cat=%b dp=%b wrap=%b exp an=%b cat=%b dp=%b wrap=%b",
                 $time, an1, cat1, dp1, sw1, e[9], e[8:2], e[1], e[0]);
      end
    end
  end
  task automatic ex(input logic [3:0] an, input logic [6:0] cat, input logic d, input logic w);
    q0.push_back({an, cat, d, w});
  endtask
  task automatic slot(input logic [3:0] an, input logic [6:0] cat, input logic d, input logic w);
    ex(4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (3) ex(an, cat, d, 1'b0);
    ex(an, cat, d, w);
  endtask
  // Reset for 3 edges (checked), release with load, then queue n cycles of the 1-digit unit.
  task automatic restart(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] e,
                         input logic l, input int n);
    @(posedge clk) #1 rst_n = 1'b0;
    @(posedge clk) #1;
    repeat (3) begin
      q0.push_back({4'hF, 7'h7F, 2'b10});
      q1.push_back({1'b1, 7'h7F, 2'b10});
    end
    @(posedge clk);
    @(posedge clk) #1;
    rst_n = 1'b1; load = 1'b1; value = v; dp_in = dpi; en = e; lz = l;
    @(posedge clk) #1 load = 1'b0;
    q1.push_back({1'b1, 7'b0000001, 2'b10});
    for (int k = 1; k < n; k++) q1.push_back({1'b0, 7'b0000000, 1'b0, k % 4 == 3});
  endtask
  initial begin
    restart(16'h1234, 4'b0000, 4'b1111, 1'b0, 40);
    repeat (2) begin
      slot(4'b1110, 7'b1001100, 1'b1, 1'b0);
      slot(4'b1101, 7'b0000110, 1'b1, 1'b0);
      slot(4'b1011, 7'b0010010, 1'b1, 1'b0);
      slot(4'b0111, 7'b1001111, 1'b1, 1'b1);
    end
    repeat (40) @(posedge clk);
    restart(16'h0050, 4'b0000, 4'b1111, 1'b1, 20);
    slot(4'b1110, 7'b0000001, 1'b1, 1'b0);
    slot(4'b1101, 7'b0100100, 1'b1, 1'b0);
    slot(4'b1111, 7'b0000001, 1'b1, 1'b0);
    slot(4'b1111, 7'b0000001, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    restart(16'h0000, 4'b0000, 4'b1111, 1'b1, 20);
    slot(4'b1110, 7'b0000001, 1'b1, 1'b0);
    slot(4'b1111, 7'b0000001, 1'b1, 1'b0);
    slot(4'b1111, 7'b0000001, 1'b1, 1'b0);
    slot(4'b1111, 7'b0000001, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    restart(16'h1234, 4'b0010, 4'b1010, 1'b0, 20);
    slot(4'b1111, 7'b1001100, 1'b1, 1'b0);
    slot(4'b1101, 7'b0000110, 1'b0, 1'b0);
    slot(4'b1111, 7'b0010010, 1'b1, 1'b0);
    slot(4'b0111, 7'b1001111, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    restart(16'h1234, 4'b0000, 4'b1111, 1'b0, 40);
    slot(4'b1110, 7'b1001100, 1'b1, 1'b0);
    slot(4'b1101, 7'b0000110, 1'b1, 1'b0);
    slot(4'b1011, 7'b0010010, 1'b1, 1'b0);
    slot(4'b0111, 7'b1001111, 1'b1, 1'b1);
    slot(4'b1110, 7'b1001100, 1'b1, 1'b0);
    slot(4'b1101, 7'b0000110, 1'b1, 1'b0);
    ex(4'b1111, 7'b1111111, 1'b1, 1'b0);
    ex(4'b1011, 7'b0010010, 1'b1, 1'b0);
    repeat (3) ex(4'b1011, 7'b0111000, 1'b1, 1'b0);
    slot(4'b0111, 7'b0111000, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1 value = 16'hFFFF;
    repeat (25) @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk) #1 load = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
